// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt front-end: synchronizes and edge-detects interrupt lines into sticky
// pending bits, then issues a prioritized, registered request to the control unit.
module otter_intr_ctrl #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic [N_SRC-1:0] i_irq_en,
  input  logic             i_csr_mie_we,
  input  logic             i_csr_mie_wd,
  input  logic             i_int_taken,
  input  logic             i_mret,
  output logic             o_intr,
  output logic [CW-1:0]    o_int_cause,
  output logic [N_SRC-1:0] o_pending,
  output logic             o_mie
);

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] r_sync;
  logic [N_SRC-1:0] r_s_d;
  logic [N_SRC-1:0] r_pending, w_pending_nxt;
  logic             r_intr, w_intr_nxt;
  logic [CW-1:0]    r_cause, w_cause_nxt;
  logic             r_mie, w_mie_nxt;
  logic             r_mpie, w_mpie_nxt;

  logic [N_SRC-1:0] w_s;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_clr;
  logic [CW-1:0]    w_win;
  logic             w_accept;

  // Multi-flop synchronizer chain plus one delay stage for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_s_d  <= '0;
    end else begin
      r_sync[0] <= i_irq_src;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_s_d <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_elig = r_pending & i_irq_en;

  // Lowest eligible index wins
  always_comb begin
    w_win = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = CW'(i);
    end
  end

  assign w_accept = (r_state == ST_ACTIVE) && i_int_taken && r_intr;
  assign w_clr    = w_accept ? (N_SRC'(1) << r_cause) : '0;

  // A same-cycle edge beats the handshake clear so no event is lost
  assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_intr_nxt  = 1'b0;
    w_cause_nxt = r_cause;
    w_mie_nxt   = r_mie;
    w_mpie_nxt  = r_mpie;

    if (i_csr_mie_we) w_mie_nxt = i_csr_mie_wd;

    case (r_state)
      ST_ACTIVE: begin
        if (w_accept) begin
          w_mpie_nxt  = r_mie;
          w_mie_nxt   = 1'b0;
          w_state_nxt = ST_HANDLER;
        end else begin
          w_intr_nxt = r_mie & (|w_elig);
          if (|w_elig) w_cause_nxt = w_win;
        end
      end
      ST_HANDLER: begin
        if (i_mret) begin
          w_mie_nxt   = r_mpie;
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: w_state_nxt = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_ACTIVE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_intr    <= 1'b0;
      r_cause   <= '0;
      r_mie     <= 1'b0;
      r_mpie    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_intr    <= w_intr_nxt;
      r_cause   <= w_cause_nxt;
      r_mie     <= w_mie_nxt;
      r_mpie    <= w_mpie_nxt;
    end
  end

  assign o_intr      = r_intr;
  assign o_int_cause = r_cause;
  assign o_pending   = r_pending;
  assign o_mie       = r_mie;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed self-checking bench for otter_intr_ctrl with hand-computed expectations.
module tb_otter_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_src;
  logic [3:0] irq_en;
  logic       csr_mie_we;
  logic       csr_mie_wd;
  logic       int_taken;
  logic       mret;
  logic       intr;
  logic [1:0] int_cause;
  logic [3:0] pending;
  logic       mie;

  int n_checks = 0;
  int n_fail   = 0;

  otter_intr_ctrl #(.N_SRC(4), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_irq_src    (irq_src),
    .i_irq_en     (irq_en),
    .i_csr_mie_we (csr_mie_we),
    .i_csr_mie_wd (csr_mie_wd),
    .i_int_taken  (int_taken),
    .i_mret       (mret),
    .o_intr       (intr),
    .o_int_cause  (int_cause),
    .o_pending    (pending),
    .o_mie        (mie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take_pulse();
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
  endtask

  task automatic mret_pulse();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_src = '0; irq_en = '0; csr_mie_we = 1'b0; csr_mie_wd = 1'b0;
    int_taken = 1'b0; mret = 1'b0;
    tick(3);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_cause", 32'(int_cause), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_mie", 32'(mie), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single source
    irq_en = 4'b1111; csr_mie_we = 1'b1; csr_mie_wd = 1'b1;
    tick();
    csr_mie_we = 1'b0;
    chk("s1_mie_set", 32'(mie), 32'd1);
    irq_src = 4'b0100;
    tick(2);
    chk("s1_pend_k1", 32'(pending), 32'h0);
    tick();
    chk("s1_pend_k2", 32'(pending), 32'h4);
    chk("s1_intr_k2", 32'(intr), 32'd0);
    irq_src = '0;
    tick();
    chk("s1_intr_k3", 32'(intr), 32'd1);
    chk("s1_cause_k3", 32'(int_cause), 32'd2);
    take_pulse();
    chk("s1_take_pend", 32'(pending), 32'h0);
    chk("s1_take_intr", 32'(intr), 32'd0);
    chk("s1_take_mie", 32'(mie), 32'd0);
    mret_pulse();
    chk("s1_mret_mie", 32'(mie), 32'd1);
    tick();
    chk("s1_idle_intr", 32'(intr), 32'd0);

    // Priority: sources 3 and 1 together
    irq_src = 4'b1010;
    tick(3);
    chk("pr_pend", 32'(pending), 32'ha);
    irq_src = '0;
    tick();
    chk("pr_intr", 32'(intr), 32'd1);
    chk("pr_cause1", 32'(int_cause), 32'd1);
    take_pulse();
    chk("pr_take_pend", 32'(pending), 32'h8);
    chk("pr_take_intr", 32'(intr), 32'd0);
    mret_pulse();
    chk("pr_mret_mie", 32'(mie), 32'd1);
    chk("pr_mret_intr0", 32'(intr), 32'd0);
    tick();
    chk("pr_reassert", 32'(intr), 32'd1);
    chk("pr_cause3", 32'(int_cause), 32'd3);
    take_pulse();
    chk("pr_take3_pend", 32'(pending), 32'h0);
    mret_pulse();

    // Masking
    csr_mie_we = 1'b1; csr_mie_wd = 1'b0;
    tick();
    csr_mie_we = 1'b0;
    chk("mk_mie_clr", 32'(mie), 32'd0);
    irq_src = 4'b0001;
    tick(3);
    chk("mk_pend", 32'(pending), 32'h1);
    irq_src = '0;
    tick();
    chk("mk_intr_masked", 32'(intr), 32'd0);
    csr_mie_we = 1'b1; csr_mie_wd = 1'b1;
    tick();
    csr_mie_we = 1'b0;
    chk("mk_mie_on", 32'(mie), 32'd1);
    chk("mk_intr_lat", 32'(intr), 32'd0);
    tick();
    chk("mk_intr_on", 32'(intr), 32'd1);
    chk("mk_cause0", 32'(int_cause), 32'd0);
    irq_en = 4'b1110;
    tick(2);
    chk("mk_en_intr", 32'(intr), 32'd0);
    chk("mk_en_pend", 32'(pending), 32'h1);
    irq_en = 4'b1111;
    tick();
    chk("mk_en_back", 32'(intr), 32'd1);

    // New edge on source 0 lands on the same edge as the take
    irq_src = 4'b0001;
    tick(2);
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    chk("sc_pend_kept", 32'(pending), 32'h1);
    chk("sc_intr", 32'(intr), 32'd0);
    chk("sc_mie", 32'(mie), 32'd0);
    irq_src = '0;
    mret_pulse();
    tick();
    chk("sc_reassert", 32'(intr), 32'd1);
    chk("sc_cause0", 32'(int_cause), 32'd0);
    take_pulse();
    chk("sc_cleared", 32'(pending), 32'h0);

    // Handler suppression, then take colliding with a CSR write
    irq_src = 4'b0010; csr_mie_we = 1'b1; csr_mie_wd = 1'b1;
    tick();
    csr_mie_we = 1'b0;
    chk("hs_mie_w", 32'(mie), 32'd1);
    tick(3);
    irq_src = '0;
    chk("hs_pend", 32'(pending), 32'h2);
    chk("hs_intr_sup", 32'(intr), 32'd0);
    mret_pulse();
    tick();
    chk("hs_intr", 32'(intr), 32'd1);
    chk("hs_cause1", 32'(int_cause), 32'd1);
    int_taken = 1'b1; csr_mie_we = 1'b1; csr_mie_wd = 1'b1;
    tick();
    int_taken = 1'b0; csr_mie_we = 1'b0;
    chk("col_mie", 32'(mie), 32'd0);
    chk("col_intr", 32'(intr), 32'd0);
    chk("col_pend", 32'(pending), 32'h0);
    mret_pulse();
    chk("col_mpie", 32'(mie), 32'd1);

    // Mret colliding with a CSR write of 0 restores mpie
    irq_src = 4'b0001;
    tick(4);
    irq_src = '0;
    chk("mc_intr", 32'(intr), 32'd1);
    take_pulse();
    mret = 1'b1; csr_mie_we = 1'b1; csr_mie_wd = 1'b0;
    tick();
    mret = 1'b0; csr_mie_we = 1'b0;
    chk("mc_mie", 32'(mie), 32'd1);

    // Async reset mid-handler with pending = 1010
    irq_src = 4'b1011;
    tick(4);
    chk("ar_cause0", 32'(int_cause), 32'd0);
    irq_src = 4'b1000;
    take_pulse();
    chk("ar_pend", 32'(pending), 32'ha);
    chk("ar_hdl_intr", 32'(intr), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_now_intr", 32'(intr), 32'd0);
    chk("ar_now_cause", 32'(int_cause), 32'd0);
    chk("ar_now_pend", 32'(pending), 32'h0);
    chk("ar_now_mie", 32'(mie), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("ar_rel_k0", 32'(pending), 32'h0);
    tick();
    chk("ar_rel_k1", 32'(pending), 32'h0);
    tick();
    chk("ar_rel_k2", 32'(pending), 32'h8);
    chk("ar_rel_mie", 32'(mie), 32'd0);
    csr_mie_we = 1'b1; csr_mie_wd = 1'b1;
    tick();
    csr_mie_we = 1'b0;
    tick();
    chk("ar_active_intr", 32'(intr), 32'd1);
    chk("ar_active_cause", 32'(int_cause), 32'd3);
    tick();
    chk("ar_no_reedge", 32'(pending), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_intr_ctrl.md
# otter_intr_ctrl

Interrupt front-end for the RISC-V OTTER, directly upstream of the control-unit FSM. It synchronizes up to N_SRC asynchronous interrupt lines and edge-detects them into sticky pending bits. It applies per-source and global enables, then drives a registered `intr` request plus a priority-encoded cause into the control unit. A two-state handshake with the control unit (`int_taken` and `mret`) clears the serviced source and masks further interrupts until the handler returns.

## Interface
- `N_SRC`, default 4: number of interrupt sources, 1..16.
- `SYNC_STAGES`, default 2: synchronizer depth per source, at least 2.
- `CW`, default $clog2(N_SRC) (1 when N_SRC=1): width of `int_cause`.

- `clk`  in  1  system clock. All state updates on its rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low. Clears all state immediately.
- `irq_src`  in  N_SRC  raw interrupt lines, asynchronous, active-high.
- `irq_en`  in  N_SRC  per-source enable (CSR mask), synchronous to `clk`.
- `csr_mie_we`  in  1  global-enable write strobe.
- `csr_mie_wd`  in  1  global-enable write data.
- `int_taken`  in  1  one-cycle pulse from the control unit when it vectors to the handler.
- `mret`  in  1  one-cycle pulse from the control unit when it executes mret.
- `intr`  out  1  registered interrupt request to the control unit.
- `int_cause`  out  CW  registered index of the source being requested.
- `pending`  out  N_SRC  sticky pending bits.
- `mie`  out  1  current global interrupt enable.

## Operation
- **Synchronizer.** Each `irq_src[i]` passes through SYNC_STAGES flops, giving `s[i]`. A further flop holds `s_d[i]`. A rising edge is `s[i] & ~s_d[i]`.
- **Pending bits.**
  - A rising edge on source i sets `pending[i]`.
  - `pending[i]` clears only on an accepted `int_taken` while `int_cause == i`.
  - If a set and a clear on the same bit land in the same cycle, the set wins and the bit stays 1.
- **Eligibility and priority.** A source is eligible when `pending[i] & irq_en[i]`. The lowest eligible index has the highest priority. A disabled source still latches its pending bit but never requests.
- **State machine.** Reset state is ACTIVE.
  - **ACTIVE**
    - The `intr` register loads `mie & |eligible`. `int_cause` loads the winning index, or holds its value when nothing is eligible.
    - `int_taken` with `intr == 1` is accepted. On acceptance: `mpie <= mie`, `mie <= 0`, the selected pending bit clears, and the FSM moves to HANDLER.
    - `int_taken` with `intr == 0` is ignored.
    - `mret` is ignored.
  - **HANDLER**
    - The `intr` register loads 0 every cycle. `int_cause` holds.
    - `mret` sets `mie <= mpie` and moves the FSM to ACTIVE.
    - `int_taken` is ignored.
- **Global-enable writes.**
  - `csr_mie_we` writes `mie` in either state.
  - In HANDLER, such a write changes `mie` but `intr` stays low.
  - If an accepted `int_taken` and `csr_mie_we` occur in the same cycle, `int_taken` wins: `mie = 0`, `mpie` receives the old `mie`, and the write is discarded.
  - If `mret` and `csr_mie_we` occur in the same cycle in HANDLER, `mret` wins: `mie = mpie`.
- **Reset values** (all outputs and internal state):
  - `intr`, `int_cause`, `pending`, `mie` and `mpie` are 0.
  - The state is ACTIVE.
  - All synchronizer and `s_d` flops are 0.
- **Reset boundary behaviour.**
  - A source held high through reset release produces exactly one edge after release, so it is latched as pending.
  - Asserting RST_N low mid-handler drops `intr` combinationally-free: it is a flop reset and is not glitched by logic. The FSM returns to ACTIVE and `mie` returns to 0.

## Timing
- **Edge to pending.** Say `irq_src[i]` rises and is first sampled at edge k. Then `pending[i]` is 1 after edge k+SYNC_STAGES, which is k+2 at the default depth.
- **Pending to request.** `intr` is 1 one edge later: k+SYNC_STAGES+1 (k+3 at the default depth), provided `mie` and `irq_en[i]` are set.
- **Source pulse width.** Source pulses shorter than one `clk` period may be missed. Sources must hold for at least 2 cycles.
- **Take handshake.** An `int_taken` accepted at edge t gives all of the following after edge t:
  - `mie = 0`
  - the selected `pending` bit = 0
  - state = HANDLER
  - `intr = 0`
- **Return handshake.** `mret` at edge t restores `mie` after edge t. If a source is still eligible, `intr` reasserts after edge t+1.
- **Enable changes.** A change to `irq_en` or `mie` reaches `intr` with 1 cycle of latency.
- **Cause validity.** `int_cause` is valid whenever `intr == 1`.

## Test plan
- **Single source.** Reset, set `mie = 1` and `irq_en = 4'b1111`, pulse `irq_src[2]` high for 3 cycles. Required: `pending = 4'b0100` at k+2, then `intr = 1` and `int_cause = 2` at k+3. Then pulse `int_taken`. Required: `pending = 0`, `intr = 0`, `mie = 0`.
- **Priority.** Raise `irq_src[3]` and `irq_src[1]` in the same cycle with everything enabled. Required: `int_cause = 1`. After take and then mret: `intr = 1` again with `int_cause = 3`.
- **Masking.** With `mie = 0`, raise `irq_src[0]`. Required: `pending[0] = 1` and `intr` stays 0. Write `mie = 1`. Required: `intr = 1` one cycle later. Clearing `irq_en[0]` instead keeps `intr = 0` while `pending[0]` stays 1.
- **Simultaneous set and clear.** During the `int_taken` cycle for source 0, a new synchronized edge arrives on source 0. Required: `pending[0]` stays 1. After `mret`, `intr` reasserts with `int_cause = 0`.
- **Handler suppression and CSR collision.** In HANDLER, raise `irq_src[1]` and write `mie = 1`. Required: `intr` stays 0. Apply `int_taken` together with `csr_mie_we = 1`, `csr_mie_wd = 1` while ACTIVE with `mie = 1`. Required: `mie = 0` and `mpie = 1`.
- **Asynchronous reset.** Pull RST_N low mid-handler with `pending = 4'b1010`. Required: all outputs 0 immediately and the state is ACTIVE. With `irq_src[3]` held high through release: `pending[3] = 1` two cycles after release.
